tone_period_classifier: RTL
===========================

Name: tone_period_classifier

Overview:
- Upstream front end of the tone-detection stage.
- Takes the comparator-squared microphone signal (tone_in) and measures the period between successive rising edges in clk cycles.
- Classifies each period into one of five tone bands and, after HITS consecutive periods of the same band, drives exactly one of bp1..bp5 high. The tone-to-direction decoder consumes bp1..bp5 directly.

Parameters:
BAND_P1, 50000, nominal period of band 1 in clk cycles (1 kHz at 50 MHz)
BAND_P2, 33333, nominal period of band 2 (1.5 kHz)
BAND_P3, 25000, nominal period of band 3 (2 kHz)
BAND_P4, 20000, nominal period of band 4 (2.5 kHz)
BAND_P5, 16667, nominal period of band 5 (3 kHz)
TOL, 1000, accepted deviation in cycles, inclusive, applied to every band
HITS, 8, consecutive same-band periods required to assert/keep lock, range 1..255
TIMEOUT, 65535, cycles without a rising edge before lock is dropped; must exceed every BAND_Pk+TOL; counter width is 17 bits

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
tone_in  in  1  asynchronous squared audio input
bp1  out  1  band 1 locked
bp2  out  1  band 2 locked
bp3  out  1  band 3 locked
bp4  out  1  band 4 locked
bp5  out  1  band 5 locked
locked  out  1  OR of bp1..bp5, registered

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Synchronizer flops, period counter, hit counter and current class all cleared to 0.
  - FSM set to IDLE; bp1..bp5 and locked set to 0.
  - Release is taken on the next clk edge.
- Input path: 2-flop synchronizer, then a third flop. edge = sync2 & ~sync3 (one-cycle pulse).
- Period P = clk cycles between consecutive edge pulses. Pulses at cycles t0 and t1 give P = t1 - t0.
  - Counter is loaded with 1 on the edge cycle and increments each cycle otherwise.
  - Counter saturates at TIMEOUT.
- Classification, on each edge with a valid reference:
  - class = lowest k with BAND_Pk-TOL <= P <= BAND_Pk+TOL.
  - If no band matches, class = 0.
  - Comparisons are unsigned, 17-bit.
- FSM states:
  - IDLE: no reference edge. An edge goes to MEASURE and starts the counter; no classification on this edge.
  - MEASURE: reference held, no lock. On edge, classify:
    - class == stored class and class != 0: hit = hit+1.
    - otherwise: stored class = class, hit = (class != 0) ? 1 : 0.
    - When hit reaches HITS: go to LOCKED and assert bp[class] on the next cycle.
  - LOCKED: on edge, classify:
    - same class: stay; hit saturates at HITS.
    - different class: clear all bp, go to MEASURE, stored class = new class, hit = (class != 0) ? 1 : 0.
- Timeout: counter reaches TIMEOUT with no edge in that cycle → go to IDLE, clear bp and hit, stored class = 0.
- Edge in the same cycle the counter reaches TIMEOUT: the edge wins and P = TIMEOUT is classified normally (class 0 with the defaults).
- Output rules:
  - At most one of bp1..bp5 is high in any cycle.
  - Outputs are registered.
  - bp goes high 4 clk after the clk edge that first samples tone_in high on the HITS-th qualifying period's closing edge: 2 sync + 1 edge register + 1 output register.
- Reset mid-lock: outputs drop immediately and asynchronously. After release, the next edge only sets the reference, so a full HITS periods are needed again.
- Glitch at start: a first period that matches no band yields class 0 and does not block the subsequent count.

Optional Feature:
- Macro: TONE_GLITCH_FILTER_EN.
- Defined: a debounce stage follows sync2. The filtered level changes only after 4 consecutive equal samples (counter reset on any disagreement). Edge detection uses the filtered level. All latencies increase by 4 clk; measured periods are unchanged for clean inputs. Pulses shorter than 4 clk are ignored.
- Not defined: sync2 feeds edge detection directly; no extra latency.

Test Plan:
- Default parameters, 2 kHz square on tone_in (25000-cycle period), 9 rising edges → bp3=1 and locked=1 exactly 4 clk after the 9th edge is sampled; the other bp lines stay 0 throughout.
- Locked on bp3, switch tone_in to 1 kHz (50000 cycles) → bp3 drops 4 clk after the first 50000-cycle edge; bp1 rises after 8 further 50000-cycle periods.
- Locked on bp5 (16667 cycles), stop tone_in low → after 65535 cycles without an edge bp5=0, locked=0, FSM in IDLE; one new edge does not change outputs.
- Period 26001 cycles (TOL+1 off band 3) repeated 20 times → no bp ever asserts. Period 26000 repeated 9 edges → bp3 asserts.
- Locked on bp2, pulse rst_n low for 3 cycles mid-period → all outputs 0 in the same cycle as rst_n falls. After release, bp2 reasserts only after 9 further edges.
- With TONE_GLITCH_FILTER_EN: 2 kHz tone plus a 2-cycle high glitch mid-period → lock on bp3 unaffected, latency 8 clk. Without the macro, the same stimulus breaks the hit count (bp3 not asserted within 9 edges).

Source files
------------

// File: rtl/tone_period_classifier.sv
// tone_period_classifier: measures rising-edge periods of a squared tone and
// locks one of five bands. Define TONE_GLITCH_FILTER_EN to add a debounce stage.
module tone_period_classifier #(
  parameter int BAND_P1 = 50000,
  parameter int BAND_P2 = 33333,
  parameter int BAND_P3 = 25000,
  parameter int BAND_P4 = 20000,
  parameter int BAND_P5 = 16667,
  parameter int TOL     = 1000,
  parameter int HITS    = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tone_in,
  output logic bp1,
  output logic bp2,
  output logic bp3,
  output logic bp4,
  output logic bp5,
  output logic locked
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEAS,
    S_LOCK
  } state_t;

  localparam logic [16:0] TMO   = 17'(TIMEOUT);
  localparam logic [7:0]  HITS8 = 8'(HITS);

  localparam logic [16:0] LO [5] = '{
    17'(BAND_P1 - TOL), 17'(BAND_P2 - TOL), 17'(BAND_P3 - TOL),
    17'(BAND_P4 - TOL), 17'(BAND_P5 - TOL)
  };
  localparam logic [16:0] HI [5] = '{
    17'(BAND_P1 + TOL), 17'(BAND_P2 + TOL), 17'(BAND_P3 + TOL),
    17'(BAND_P4 + TOL), 17'(BAND_P5 + TOL)
  };

  logic        sync1;
  logic        sync2;
  logic        lvl;
  logic        sync3;
  logic        edge_q;
  logic [16:0] cnt;
  logic [7:0]  hit;
  logic [7:0]  hit_new;
  logic [2:0]  cls;
  logic [2:0]  cls_new;
  logic        timeout;
  state_t      state;
  state_t      state_nx;
  logic [4:0]  bp_d;
  logic [4:0]  bp_q;
  logic        lock_d;

  // Two-flop synchronizer, level delay and registered edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync1  <= tone_in;
      sync2  <= sync1;
      sync3  <= lvl;
      edge_q <= lvl & ~sync3;
    end
  end

`ifdef TONE_GLITCH_FILTER_EN
  logic       filt;
  logic [1:0] fcnt;

  // Debounce: follow sync2 only after 4 consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b0;
      fcnt <= 2'd0;
    end else if (sync2 == filt) begin
      fcnt <= 2'd0;
    end else if (fcnt == 2'd3) begin
      filt <= sync2;
      fcnt <= 2'd0;
    end else begin
      fcnt <= fcnt + 2'd1;
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync2;
`endif

  // Period counter: 1 on the edge cycle, then counts up to TIMEOUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 17'd0;
    end else if (edge_q) begin
      cnt <= 17'd1;
    end else if (cnt != TMO) begin
      cnt <= cnt + 17'd1;
    end
  end

  // Band match on the current count; descending loop so lowest band wins
  always_comb begin
    cls_new = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      if (cnt >= LO[k] && cnt <= HI[k]) begin
        cls_new = 3'(k + 1);
      end
    end
  end

  // Hit count for this edge and the no-edge timeout condition
  always_comb begin
    hit_new = {7'd0, cls_new != 3'd0};
    if (cls_new != 3'd0 && cls_new == cls) begin
      hit_new = (hit >= HITS8) ? HITS8 : hit + 8'd1;
    end
    timeout = (cnt == TMO) && !edge_q;
  end

  // Stored class and hit counter, updated on edges with a reference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls <= 3'd0;
      hit <= 8'd0;
    end else if (state != S_IDLE) begin
      if (edge_q) begin
        cls <= cls_new;
        hit <= hit_new;
      end else if (timeout) begin
        cls <= 3'd0;
        hit <= 8'd0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (edge_q) state_nx = S_MEAS;
      end
      S_MEAS: begin
        if (edge_q) begin
          if (cls_new != 3'd0 && hit_new >= HITS8) state_nx = S_LOCK;
        end else if (timeout) begin
          state_nx = S_IDLE;
        end
      end
      S_LOCK: begin
        if (edge_q) begin
          if (cls_new != cls) state_nx = S_MEAS;
        end else if (timeout) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs: one-hot band decode while locked
  always_comb begin
    bp_d   = 5'd0;
    lock_d = 1'b0;
    if (state == S_LOCK && cls != 3'd0) begin
      bp_d   = 5'b00001 << (cls - 3'd1);
      lock_d = 1'b1;
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_q   <= 5'd0;
      locked <= 1'b0;
    end else begin
      bp_q   <= bp_d;
      locked <= lock_d;
    end
  end

  assign bp1 = bp_q[0];
  assign bp2 = bp_q[1];
  assign bp3 = bp_q[2];
  assign bp4 = bp_q[3];
  assign bp5 = bp_q[4];

endmodule
